// File: rtl/ucaspian_metric_bank_if.sv
// Byte-serial metric read bus between the packet decoder (master) and the metric bank (slave).
interface ucaspian_metric_bank_if;
   logic [7:0] metric_addr;
   logic       metric_read;
   logic [7:0] metric_value;
   logic       metric_send;

   modport master (output metric_addr, metric_read, input  metric_value, metric_send);
   modport slave  (input  metric_addr, metric_read, output metric_value, metric_send);
endinterface

// File: rtl/ucaspian_metric_bank.sv
// Bank of NUM_CNT event counters with a byte-serial read port, tear-free multi-byte reads via a
// shared snapshot, optional clear-on-read and optional saturation.
module ucaspian_metric_cnt #(
   parameter int CNT_W         = 32,
   parameter int SATURATE      = 0,
   parameter int CLEAR_ON_READ = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             inc,
   input  logic             rd_msb,
   output logic [CNT_W-1:0] cnt_q
);
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if ((CLEAR_ON_READ != 0) && rd_msb) begin
         // restart from this cycle's event so nothing is lost across the read
         cnt_d = CNT_W'(inc);
      end else if (inc) begin
         if (&cnt_q) cnt_d = (SATURATE != 0) ? cnt_q : '0;
         else        cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

module ucaspian_metric_bank #(
   parameter int NUM_CNT       = 3,
   parameter int CNT_W         = 32,
   parameter int SATURATE      = 0,
   parameter int CLEAR_ON_READ = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [NUM_CNT-1:0]   inc,
   ucaspian_metric_bank_if.slave mif
);
   localparam int BYTES  = CNT_W / 8;
   localparam int NBYTES = NUM_CNT * BYTES;
   localparam int IDX_W  = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
   localparam int BI_W   = (BYTES > 1) ? $clog2(BYTES) : 1;

   if (NUM_CNT < 1 || NUM_CNT > 16) begin : g_bad_num
      $error("NUM_CNT must be 1..16");
   end
   if (CNT_W < 8 || CNT_W > 64 || (CNT_W % 8) != 0) begin : g_bad_w
      $error("CNT_W must be a multiple of 8 in 8..64");
   end
   if (1 + NBYTES > 256) begin : g_bad_map
      $error("address map does not fit in 8 bits");
   end

   logic [NUM_CNT-1:0][CNT_W-1:0] cnt;
   logic [NUM_CNT-1:0]            rd_msb;
   logic [CNT_W-1:0]              snap_q, snap_d, src;
   logic [7:0]                    value_q, value_d, rd_byte;
   logic                          send_q, send_d;
   logic                          accept, in_range, msb_sel;
   logic [8:0]                    off;
   logic [IDX_W-1:0]              sel;
   logic [BI_W-1:0]               bsel;

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      ucaspian_metric_cnt #(
         .CNT_W(CNT_W), .SATURATE(SATURATE), .CLEAR_ON_READ(CLEAR_ON_READ)
      ) u_cnt (
         .clk(clk), .reset(reset), .clear(clear), .inc(inc[g]),
         .rd_msb(rd_msb[g]), .cnt_q(cnt[g])
      );
   end

   // address decode: 1 + i*BYTES + j -> counter i, byte j (j=0 is MSB)
   always_comb begin
      off      = {1'b0, mif.metric_addr} - 9'd1;
      in_range = (mif.metric_addr != 8'd0) && (off < 9'(NBYTES));
      sel      = '0;
      bsel     = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (off >= 9'(i * BYTES) && off < 9'((i + 1) * BYTES)) begin
            sel  = IDX_W'(i);
            bsel = BI_W'(off - 9'(i * BYTES));
         end
      end
      msb_sel = in_range && (bsel == '0);
   end

   always_comb begin
      accept = mif.metric_read && !send_q;
      // MSB read returns the live counter (which is what gets snapshotted); others the snapshot
      src    = msb_sel ? cnt[sel] : snap_q;
      if (mif.metric_addr == 8'd0)  rd_byte = 8'(NUM_CNT);
      else if (!in_range || clear)  rd_byte = 8'd0;
      else                          rd_byte = 8'(src >> (8 * (BYTES - 1 - int'(bsel))));

      rd_msb = '0;
      for (int i = 0; i < NUM_CNT; i++)
         rd_msb[i] = accept && msb_sel && (sel == IDX_W'(i));

      snap_d = snap_q;
      if (clear)                  snap_d = '0;
      else if (accept && msb_sel) snap_d = cnt[sel];

      value_d = accept ? rd_byte : value_q;

      send_d = send_q;
      if (accept)                 send_d = 1'b1;
      else if (!mif.metric_read)  send_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         snap_q  <= '0;
         value_q <= '0;
         send_q  <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         value_q <= value_d;
         send_q  <= send_d;
      end
   end

   assign mif.metric_value = value_q;
   assign mif.metric_send  = send_q & mif.metric_read;
endmodule

// File: tb/tb_ucaspian_metric_bank.sv
// Scoreboard bench: three bank configurations driven in lockstep, checked against a counter-array model.
module tb_ucaspian_metric_bank;
   typedef logic [2:0][7:0] exp_t;

   logic       clk, reset, clear, rd;
   logic [3:0] inc;
   logic [7:0] addr;

   ucaspian_metric_bank_if mif_a ();
   ucaspian_metric_bank_if mif_b ();
   ucaspian_metric_bank_if mif_c ();

   assign mif_a.metric_addr = addr;
   assign mif_b.metric_addr = addr;
   assign mif_c.metric_addr = addr;
   assign mif_a.metric_read = rd;
   assign mif_b.metric_read = rd;
   assign mif_c.metric_read = rd;

   ucaspian_metric_bank #(.NUM_CNT(3), .CNT_W(32), .SATURATE(0), .CLEAR_ON_READ(1)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .inc(inc[2:0]), .mif(mif_a));
   ucaspian_metric_bank #(.NUM_CNT(2), .CNT_W(8), .SATURATE(1), .CLEAR_ON_READ(1)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .inc(inc[1:0]), .mif(mif_b));
   ucaspian_metric_bank #(.NUM_CNT(4), .CNT_W(8), .SATURATE(0), .CLEAR_ON_READ(0)) dut_c (
      .clk(clk), .reset(reset), .clear(clear), .inc(inc[3:0]), .mif(mif_c));

   int NCNT  [3] = '{3, 2, 4};
   int NBYT  [3] = '{4, 1, 1};
   int SAT   [3] = '{0, 1, 0};
   int COR   [3] = '{1, 1, 0};

   logic [63:0] mcnt  [3][4];
   logic [63:0] msnap [3];
   exp_t        expq [$];
   exp_t        last_e;
   int          checks = 0;
   int          errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] sends();
      return {mif_c.metric_send, mif_b.metric_send, mif_a.metric_send};
   endfunction

   // One clock of the reference: counters are plain integers, reads decoded by arithmetic.
   function automatic void model_step(bit rst, bit clr, logic [3:0] iv, bit acc, logic [7:0] a);
      exp_t        ev;
      int          nb, i, j;
      bit          rdclr;
      logic [63:0] maxv;
      ev = '0;
      for (int k = 0; k < 3; k++) begin
         rdclr = 0;
         i     = 0;
         maxv  = (64'd1 << (8 * NBYT[k])) - 64'd1;
         if (rst) begin
            for (int n = 0; n < 4; n++) mcnt[k][n] = 0;
            msnap[k] = 0;
         end else begin
            if (clr) begin
               for (int n = 0; n < 4; n++) mcnt[k][n] = 0;
               msnap[k] = 0;
            end
            if (acc) begin
               nb = NCNT[k] * NBYT[k];
               if (a == 8'd0) ev[k] = 8'(NCNT[k]);
               else if (int'(a) <= nb) begin
                  i = (int'(a) - 1) / NBYT[k];
                  j = (int'(a) - 1) % NBYT[k];
                  if (j == 0) begin
                     msnap[k] = mcnt[k][i];
                     rdclr    = (COR[k] != 0) && !clr;
                  end
                  ev[k] = 8'(msnap[k] >> (8 * (NBYT[k] - 1 - j)));
               end
            end
            if (!clr) begin
               for (int n = 0; n < NCNT[k]; n++) begin
                  if (rdclr && n == i) mcnt[k][n] = 64'(iv[n]);
                  else if (iv[n])
                     mcnt[k][n] = (mcnt[k][n] == maxv) ? ((SAT[k] != 0) ? maxv : 64'd0)
                                                      : mcnt[k][n] + 64'd1;
               end
            end
         end
      end
      if (acc) expq.push_back(ev);
   endfunction

   task automatic step(input bit acc, input logic [3:0] iv, input bit clr);
      inc   = iv;
      clear = clr;
      model_step(reset, clr, iv, acc, addr);
      @(negedge clk);
   endtask

   task automatic do_read(input logic [7:0] a, input int hold, input bit rnd, input logic [3:0] iv_acc);
      addr = a;
      rd   = 1'b1;
      step(1, rnd ? 4'($urandom) : iv_acc, rnd && ($urandom_range(0, 15) == 0));
      chk("send_latency", 32'(sends()), 32'h7);
      repeat (hold) begin
         step(0, rnd ? 4'($urandom) : 4'd0, rnd && ($urandom_range(0, 15) == 0));
         chk("send_held", 32'(sends()), 32'h7);
      end
      rd = 1'b0;
      #1;
      chk("send_drop", 32'(sends()), 32'h0);
      step(0, rnd ? 4'($urandom) : 4'd0, 0);
   endtask

   // monitor: one expected entry per rising edge of metric_send
   bit         prev_send = 0;
   logic [2:0] s_mon;
   always @(posedge clk) begin
      #2;
      s_mon = sends();
      if (s_mon == 3'b111 && !prev_send) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_send got=send want=no_send t=%0t", $time);
         end else begin
            last_e = expq.pop_front();
            chk("value_a", 32'(mif_a.metric_value), 32'(last_e[0]));
            chk("value_b", 32'(mif_b.metric_value), 32'(last_e[1]));
            chk("value_c", 32'(mif_c.metric_value), 32'(last_e[2]));
         end
      end else if (s_mon != 3'b000 && s_mon != 3'b111) begin
         chk("send_lockstep", 32'(s_mon), 32'h7);
      end
      prev_send = (s_mon == 3'b111);
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; rd = 1'b0; inc = '0; addr = '0;
      for (int k = 0; k < 3; k++) begin
         msnap[k] = 0;
         for (int n = 0; n < 4; n++) mcnt[k][n] = 0;
      end
      @(negedge clk);
      repeat (2) step(0, 4'd0, 0);
      chk("reset_send", 32'(sends()), 32'h0);
      chk("reset_value", {8'd0, mif_c.metric_value, mif_b.metric_value, mif_a.metric_value}, 32'h0);
      reset = 1'b0;

      // counter 0 counts five events, then byte-wise read
      repeat (5) step(0, 4'b0001, 0);
      for (int a = 1; a <= 4; a++) do_read(8'(a), 0, 0, 4'd0);

      // 300 events on every counter: wrap, saturate, multi-byte snapshot
      step(0, 4'd0, 1);
      repeat (300) step(0, 4'b1111, 0);
      do_read(8'd1, 0, 0, 4'd0);
      do_read(8'd1, 1, 0, 4'd0);
      do_read(8'd2, 0, 0, 4'd0);
      do_read(8'd3, 0, 0, 4'd0);
      do_read(8'd4, 2, 0, 4'd0);
      do_read(8'd5, 0, 0, 4'b0010);
      for (int a = 6; a <= 8; a++) do_read(8'(a), 0, 0, 4'd0);
      do_read(8'd5, 0, 0, 4'd0);
      do_read(8'd0, 0, 0, 4'd0);
      do_read(8'd13, 0, 0, 4'd0);
      do_read(8'd255, 0, 0, 4'd0);
      do_read(8'd2, 0, 0, 4'd0);

      // clear while a byte is being delivered
      repeat (20) step(0, 4'b1111, 0);
      addr = 8'd3; rd = 1'b1;
      step(1, 4'd0, 0);
      chk("send_latency", 32'(sends()), 32'h7);
      step(0, 4'b1111, 1);
      chk("send_over_clear", 32'(sends()), 32'h7);
      chk("value_over_clear", {8'd0, mif_c.metric_value, mif_b.metric_value, mif_a.metric_value},
          {8'd0, last_e[2], last_e[1], last_e[0]});
      rd = 1'b0;
      step(0, 4'd0, 0);
      for (int a = 1; a <= 5; a++) do_read(8'(a), 0, 0, 4'd0);

      // reset in the middle of a handshake
      repeat (7) step(0, 4'b1111, 0);
      addr = 8'd1; rd = 1'b1;
      step(1, 4'd0, 0);
      chk("send_latency", 32'(sends()), 32'h7);
      reset = 1'b1;
      step(0, 4'd0, 0);
      chk("reset_mid_send", 32'(sends()), 32'h0);
      chk("reset_mid_value", {8'd0, mif_c.metric_value, mif_b.metric_value, mif_a.metric_value}, 32'h0);
      rd = 1'b0; reset = 1'b0;
      step(0, 4'd0, 0);
      do_read(8'd0, 0, 0, 4'd0);
      do_read(8'd2, 0, 0, 4'd0);

      // random traffic
      for (int r = 0; r < 300; r++) begin
         int gap;
         logic [7:0] ra;
         gap = $urandom_range(0, 2);
         repeat (gap) step(0, 4'($urandom), $urandom_range(0, 19) == 0);
         case ($urandom_range(0, 9))
            0:       ra = 8'd0;
            1:       ra = 8'($urandom_range(0, 255));
            default: ra = 8'($urandom_range(1, 13));
         endcase
         do_read(ra, $urandom_range(0, 2), 1, 4'd0);
      end

      repeat (3) step(0, 4'd0, 0);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
